// File: rtl/mdio_pkg.sv
// mdio_pkg: shared types and constants for the MDIO responder.
// Frame states, opcodes, register indices and reset values.
package mdio_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ST,
        S_OP,
        S_PHYAD,
        S_REGAD,
        S_TA,
        S_DATA
    } mdio_state_t;

    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_WRITE = 2'b01;

    localparam logic [4:0] REG_BMCR = 5'd0;
    localparam logic [4:0] REG_BMSR = 5'd1;
    localparam logic [4:0] REG_ID1  = 5'd2;
    localparam logic [4:0] REG_ID2  = 5'd3;

    localparam logic [5:0]  PREAMBLE_ONES  = 6'd32;
    localparam logic [15:0] BMCR_RESET     = 16'h1140;
    localparam logic [15:0] BMSR_BASE      = 16'h7949;
    localparam logic [15:0] BMSR_LINK_MASK = 16'h0024;

    // Only BMCR and the generic registers above ID2 accept writes
    function automatic logic reg_writable(input logic [4:0] a);
        return (a == REG_BMCR) || (a > REG_ID2);
    endfunction

endpackage

// File: rtl/mdio_edge_sync.sv
// mdio_edge_sync: brings MDC/MDIO into the clk domain.
// Produces a one-clk pulse on each synchronized MDC rise.
module mdio_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic mdc,
    input  logic mdio_i,
    output logic mdc_rise,
    output logic mdio_s
);

    logic [1:0] mdc_sync;
    logic       mdc_prev;
    logic [1:0] mdio_sync;

    // Two-stage synchronizers plus the previous MDC level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mdc_sync  <= '0;
            mdc_prev  <= 1'b0;
            mdio_sync <= '0;
        end else begin
            mdc_sync  <= {mdc_sync[0], mdc};
            mdc_prev  <= mdc_sync[1];
            mdio_sync <= {mdio_sync[0], mdio_i};
        end
    end

    assign mdc_rise = mdc_sync[1] & ~mdc_prev;
    assign mdio_s   = mdio_sync[1];

endmodule

// File: rtl/mdio_responder.sv
// mdio_responder: Clause-22 MDIO target with a 32x16 register file.
// Define MDIO_BCAST_EN to also accept writes addressed to PHYAD 0.
module mdio_responder #(
    parameter logic [4:0]  PHY_ADDR = 5'd1,
    parameter logic [31:0] PHY_ID   = 32'h001C_C915
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        link_i,
    output logic        wr_valid,
    output logic [4:0]  wr_addr,
    output logic [15:0] wr_data,
    output logic        frame_err
);

    import mdio_pkg::*;

    logic        mdc_rise;
    logic        mdio_bit;

    mdio_state_t state, state_n;
    logic [5:0]  ones, ones_n;
    logic [3:0]  bcnt, bcnt_n;
    logic [1:0]  op, op_n;
    logic [4:0]  phy, phy_n;
    logic [4:0]  rega, rega_n;
    logic [15:0] sh, sh_n;
    logic        mdo_n, oe_n, wv_n, ferr_n;
    logic [4:0]  wa_n;
    logic [15:0] wd_n;

    logic [15:0] rf [32];
    logic        rf_we;
    logic [4:0]  rega_full;
    logic [15:0] wdata_full;
    logic [15:0] rd_val;
    logic        rd_hit, wr_hit;
    logic        rd_act, wr_act;

    mdio_edge_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .mdc      (mdc),
        .mdio_i   (mdio_i),
        .mdc_rise (mdc_rise),
        .mdio_s   (mdio_bit)
    );

    assign rega_full  = {rega[3:0], mdio_bit};
    assign wdata_full = {sh[14:0], mdio_bit};
    assign rd_hit     = (phy == PHY_ADDR);

`ifdef MDIO_BCAST_EN
    assign wr_hit = rd_hit | (phy == 5'd0);
`else
    assign wr_hit = rd_hit;
`endif

    assign rd_act = (op == OP_READ) && rd_hit;
    assign wr_act = (op == OP_WRITE) && wr_hit
                 && reg_writable(rega);

    // Register read mux, evaluated on the last REGAD bit
    always_comb begin
        rd_val = rf[rega_full];
        unique case (1'b1)
            (rega_full == REG_BMSR):
                rd_val = BMSR_BASE
                       | (link_i ? BMSR_LINK_MASK : 16'h0);
            (rega_full == REG_ID1): rd_val = PHY_ID[31:16];
            (rega_full == REG_ID2): rd_val = PHY_ID[15:0];
            default: ;
        endcase
    end

    // Frame decoder next-state, datapath and output logic
    always_comb begin
        state_n = state;
        ones_n  = ones;
        bcnt_n  = bcnt;
        op_n    = op;
        phy_n   = phy;
        rega_n  = rega;
        sh_n    = sh;
        mdo_n   = mdio_o;
        oe_n    = mdio_oe;
        wv_n    = 1'b0;
        wa_n    = wr_addr;
        wd_n    = wr_data;
        ferr_n  = 1'b0;
        rf_we   = 1'b0;
        if (mdc_rise) begin
            unique case (state)
                S_IDLE: begin
                    if (mdio_bit) begin
                        if (ones != PREAMBLE_ONES)
                            ones_n = ones + 6'd1;
                    end else if (ones == PREAMBLE_ONES) begin
                        state_n = S_ST;
                        ones_n  = '0;
                    end else begin
                        ones_n = '0;
                    end
                end
                S_ST: begin
                    if (mdio_bit) begin
                        state_n = S_OP;
                        bcnt_n  = '0;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = S_IDLE;
                    end
                end
                S_OP: begin
                    op_n = {op[0], mdio_bit};
                    if (bcnt == 4'd1) begin
                        bcnt_n = '0;
                        if (op_n == OP_READ || op_n == OP_WRITE) begin
                            state_n = S_PHYAD;
                        end else begin
                            ferr_n  = 1'b1;
                            state_n = S_IDLE;
                        end
                    end else begin
                        bcnt_n = bcnt + 4'd1;
                    end
                end
                S_PHYAD: begin
                    phy_n = {phy[3:0], mdio_bit};
                    if (bcnt == 4'd4) begin
                        bcnt_n  = '0;
                        state_n = S_REGAD;
                    end else begin
                        bcnt_n = bcnt + 4'd1;
                    end
                end
                S_REGAD: begin
                    rega_n = rega_full;
                    if (bcnt == 4'd4) begin
                        bcnt_n  = '0;
                        state_n = S_TA;
                        sh_n    = rd_val;
                    end else begin
                        bcnt_n = bcnt + 4'd1;
                    end
                end
                S_TA: begin
                    if (bcnt == 4'd0) begin
                        bcnt_n = 4'd1;
                        if (rd_act) begin
                            oe_n  = 1'b1;
                            mdo_n = 1'b0;
                        end
                    end else begin
                        bcnt_n  = '0;
                        state_n = S_DATA;
                        if (rd_act) begin
                            mdo_n = sh[15];
                            sh_n  = {sh[14:0], 1'b0};
                        end
                    end
                end
                S_DATA: begin
                    if (rd_act) begin
                        if (bcnt == 4'd15) begin
                            oe_n  = 1'b0;
                            mdo_n = 1'b0;
                        end else begin
                            mdo_n = sh[15];
                            sh_n  = {sh[14:0], 1'b0};
                        end
                    end else if (op == OP_WRITE) begin
                        sh_n = wdata_full;
                    end
                    if (bcnt == 4'd15) begin
                        bcnt_n  = '0;
                        state_n = S_IDLE;
                        if (wr_act) begin
                            wv_n  = 1'b1;
                            wa_n  = rega;
                            wd_n  = wdata_full;
                            rf_we = 1'b1;
                        end
                    end else begin
                        bcnt_n = bcnt + 4'd1;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ones      <= '0;
            bcnt      <= '0;
            op        <= '0;
            phy       <= '0;
            rega      <= '0;
            sh        <= '0;
            mdio_o    <= 1'b0;
            mdio_oe   <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_n;
            ones      <= ones_n;
            bcnt      <= bcnt_n;
            op        <= op_n;
            phy       <= phy_n;
            rega      <= rega_n;
            sh        <= sh_n;
            mdio_o    <= mdo_n;
            mdio_oe   <= oe_n;
            wr_valid  <= wv_n;
            wr_addr   <= wa_n;
            wr_data   <= wd_n;
            frame_err <= ferr_n;
        end
    end

    // Register file; BMCR bit 15 restores defaults and never sticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++)
                rf[i] <= (i == 0) ? BMCR_RESET : 16'h0;
        end else if (rf_we) begin
            if (rega == REG_BMCR && wdata_full[15]) begin
                for (int i = 0; i < 32; i++)
                    rf[i] <= (i == 0) ? BMCR_RESET : 16'h0;
            end else if (rega == REG_BMCR) begin
                rf[0] <= {1'b0, wdata_full[14:0]};
            end else begin
                rf[rega] <= wdata_full;
            end
        end
    end

endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: drives MDC/MDIO frames as a master would.
// Checks the responder against a register-level model.
module tb_mdio_responder;

`ifdef MDIO_BCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mdc = 1'b0;
    logic        mst_drive = 1'b1;
    logic        link = 1'b0;
    logic        mdio_pad;
    logic        mdio_o, mdio_oe;
    logic        wr_valid, frame_err;
    logic [4:0]  wr_addr;
    logic [15:0] wr_data;

    int total = 0;
    int bad = 0;

    logic [15:0] m_rf [32];
    bit          drive_ok = 1'b0;
    bit          prev_clean = 1'b1;
    logic [20:0] exp_wr [$];
    int          exp_ferr = 0;
    logic [20:0] wr_e;

    assign mdio_pad = mdio_oe ? mdio_o : mst_drive;

    always #5 clk = ~clk;

    mdio_responder #(
        .PHY_ADDR (5'd1),
        .PHY_ID   (32'h001C_C915)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mdc       (mdc),
        .mdio_i    (mdio_pad),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .link_i    (link),
        .wr_valid  (wr_valid),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .frame_err (frame_err)
    );

    function automatic void m_defaults();
        for (int i = 0; i < 32; i++) m_rf[i] = 16'h0;
        m_rf[0] = 16'h1140;
    endfunction

    function automatic logic [15:0] m_read(input logic [4:0] a);
        if (a == 5'd1)
            return 16'h7949 | ({15'd0, link} << 2)
                            | ({15'd0, link} << 5);
        if (a == 5'd2) return 16'h001C;
        if (a == 5'd3) return 16'hC915;
        return m_rf[a];
    endfunction

    function automatic bit m_writable(input logic [4:0] a);
        return (a == 5'd0) || (a >= 5'd4);
    endfunction

    function automatic void m_write(input logic [4:0] a,
                                    input logic [15:0] d);
        if (a == 5'd0 && d[15]) m_defaults();
        else m_rf[a] = d;
    endfunction

    task automatic check16(input string name, input logic [15:0] act,
                           input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act,
                          input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checkn(input string name, input int act,
                          input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One MDC bit: drive while MDC low, sample just after the rise
    task automatic send(input logic b, input bit rel, output logic s);
        mst_drive = rel ? 1'b1 : b;
        repeat (8) @(posedge clk);
        mdc = 1'b1;
        @(negedge clk);
        s = mdio_pad;
        repeat (8) @(posedge clk);
        mdc = 1'b0;
    endtask

    task automatic do_frame(input int pre, input logic st1,
                            input logic [1:0] op, input logic [4:0] phy,
                            input logic [4:0] ra, input logic [15:0] wd,
                            input int rst_at, output logic [15:0] rd);
        bit decoded, err, ok, is_rd, hit_rd, hit_wr, did_rst;
        logic [15:0] exp_rd;
        logic s, ta1, ta2;
        decoded = (pre >= 32);
        err = decoded && (st1 != 1'b1 || op == 2'b00 || op == 2'b11);
        ok = decoded && !err;
        is_rd = (op == 2'b10);
        hit_rd = ok && is_rd && (phy == 5'd1);
        hit_wr = ok && (op == 2'b01) && m_writable(ra)
              && (phy == 5'd1 || (BCAST && phy == 5'd0));
        exp_rd = m_read(ra);
        did_rst = 1'b0;
        rd = 16'hFFFF;
        ta1 = 1'b1;
        ta2 = 1'b1;
        if (err) exp_ferr++;
        if (hit_wr) exp_wr.push_back({ra, wd});
        for (int i = 0; i < pre; i++) send(1'b1, 1'b0, s);
        send(1'b0, 1'b0, s);
        send(st1, 1'b0, s);
        send(op[1], 1'b0, s);
        send(op[0], 1'b0, s);
        for (int i = 4; i >= 0; i--) send(phy[i], 1'b0, s);
        for (int i = 4; i >= 0; i--) send(ra[i], 1'b0, s);
        if (is_rd) begin
            drive_ok = hit_rd;
            send(1'b1, 1'b1, ta1);
            send(1'b1, 1'b1, ta2);
        end else begin
            send(1'b1, 1'b0, s);
            send(1'b0, 1'b0, s);
        end
        for (int i = 15; i >= 0; i--) begin
            if (is_rd && (15 - i) == rst_at) begin
                if (hit_rd) check1("oe_before_rst", mdio_oe, 1'b1);
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                check1("oe_on_rst", mdio_oe, 1'b0);
                drive_ok = 1'b0;
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                m_defaults();
                exp_wr.delete();
                exp_ferr = 0;
                did_rst = 1'b1;
            end
            if (is_rd) begin
                send(1'b1, 1'b1, s);
                rd[i] = s;
            end else begin
                send(wd[i], 1'b0, s);
            end
        end
        mst_drive = 1'b1;
        repeat (4) @(posedge clk);
        drive_ok = 1'b0;
        @(negedge clk);
        check1("oe_released", mdio_oe, 1'b0);
        checkn("wr_pending", exp_wr.size(), 0);
        checkn("ferr_pending", exp_ferr, 0);
        if (hit_rd && !did_rst) begin
            check1("ta1_released", ta1, 1'b1);
            check1("ta2_zero", ta2, 1'b0);
            check16("read_data", rd, exp_rd);
        end else if (is_rd && !did_rst) begin
            check16("no_drive", rd, 16'hFFFF);
        end
        if (hit_wr) m_write(ra, wd);
        prev_clean = ok && !did_rst;
    endtask

    // Pulse and drive-window checks against the model every cycle
    always @(negedge clk) begin
        total++;
        if (mdio_oe && !drive_ok) begin
            bad++;
            if (bad < 40)
                $display("FAIL oe_window: mdio_oe=%b allowed=%b",
                         mdio_oe, drive_ok);
        end
        if (wr_valid) begin
            total++;
            if (exp_wr.size() == 0) begin
                bad++;
                $display("FAIL wr_unexpected: addr=%0d data=%h none due",
                         wr_addr, wr_data);
            end else begin
                wr_e = exp_wr.pop_front();
                if ({wr_addr, wr_data} !== wr_e) begin
                    bad++;
                    $display("FAIL wr_pulse: got %0d/%h expected %0d/%h",
                             wr_addr, wr_data, wr_e[20:16], wr_e[15:0]);
                end
            end
        end
        if (frame_err) begin
            total++;
            if (exp_ferr == 0) begin
                bad++;
                $display("FAIL ferr_unexpected: got 1 expected 0");
            end else begin
                exp_ferr--;
            end
        end
    end

    initial begin
        logic [15:0] rd;
        int r;
        logic [1:0] op;
        logic [4:0] phy, ra;
        logic [15:0] wd;
        logic st1;
        int pre;
        m_defaults();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check1("rst_oe", mdio_oe, 1'b0);
        check1("rst_o", mdio_o, 1'b0);
        check1("rst_wv", wr_valid, 1'b0);
        check1("rst_ferr", frame_err, 1'b0);
        checkn("rst_waddr", int'(wr_addr), 0);
        check16("rst_wdata", wr_data, 16'h0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        do_frame(32, 1'b1, 2'b10, 5'd1, 5'd0, 16'h0, -1, rd);
        check16("lit_reg0_reset", rd, 16'h1140);
        do_frame(32, 1'b1, 2'b01, 5'd1, 5'd4, 16'hA5C3, -1, rd);
        do_frame(32, 1'b1, 2'b10, 5'd1, 5'd4, 16'h0, -1, rd);
        check16("lit_reg4", rd, 16'hA5C3);
        do_frame(32, 1'b1, 2'b10, 5'd1, 5'd2, 16'h0, -1, rd);
        check16("lit_id1", rd, 16'h001C);
        do_frame(32, 1'b1, 2'b10, 5'd1, 5'd3, 16'h0, -1, rd);
        check16("lit_id2", rd, 16'hC915);
        do_frame(32, 1'b1, 2'b01, 5'd1, 5'd3, 16'h0000, -1, rd);
        do_frame(32, 1'b1, 2'b10, 5'd1, 5'd3, 16'h0, -1, rd);
        check16("lit_id2_ro", rd, 16'hC915);

        do_frame(31, 1'b1, 2'b01, 5'd1, 5'd5, 16'h1234, -1, rd);
        do_frame(32, 1'b1, 2'b10, 5'd1, 5'd5, 16'h0, -1, rd);
        check16("lit_short_pre_wr", rd, 16'h0000);
        do_frame(31, 1'b1, 2'b10, 5'd1, 5'd0, 16'h0, -1, rd);
        check16("lit_short_pre_rd", rd, 16'hFFFF);
        do_frame(32, 1'b1, 2'b11, 5'd1, 5'd0, 16'h5555, -1, rd);

        do_frame(32, 1'b1, 2'b01, 5'd1, 5'd4, 16'h0F0F, -1, rd);
        do_frame(32, 1'b1, 2'b01, 5'd1, 5'd0, 16'h8000, -1, rd);
        do_frame(32, 1'b1, 2'b10, 5'd1, 5'd0, 16'h0, -1, rd);
        check16("lit_bmcr_reset", rd, 16'h1140);
        do_frame(32, 1'b1, 2'b10, 5'd1, 5'd4, 16'h0, -1, rd);
        check16("lit_reg4_cleared", rd, 16'h0000);
        link = 1'b1;
        do_frame(32, 1'b1, 2'b10, 5'd1, 5'd1, 16'h0, -1, rd);
        check16("lit_bmsr_link", rd, 16'h796D);
        link = 1'b0;
        do_frame(32, 1'b1, 2'b10, 5'd1, 5'd1, 16'h0, -1, rd);
        check16("lit_bmsr_nolink", rd, 16'h7949);

        do_frame(32, 1'b1, 2'b01, 5'd1, 5'd4, 16'hBEEF, -1, rd);
        do_frame(32, 1'b1, 2'b10, 5'd1, 5'd4, 16'h0, 7, rd);
        do_frame(32, 1'b1, 2'b10, 5'd1, 5'd4, 16'h0, -1, rd);
        check16("lit_reg4_after_rst", rd, 16'h0000);

        do_frame(32, 1'b1, 2'b01, 5'd0, 5'd6, 16'h6666, -1, rd);
        do_frame(32, 1'b1, 2'b10, 5'd1, 5'd6, 16'h0, -1, rd);
        check16("lit_bcast", rd, BCAST ? 16'h6666 : 16'h0000);
        do_frame(32, 1'b1, 2'b10, 5'd0, 5'd6, 16'h0, -1, rd);
        do_frame(32, 1'b0, 2'b01, 5'd1, 5'd7, 16'h7777, -1, rd);

        for (int n = 0; n < 24; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 45) op = 2'b10;
            else if (r < 88) op = 2'b01;
            else if (r[0]) op = 2'b11;
            else op = 2'b00;
            r = int'($urandom_range(0, 9));
            if (r < 7) phy = 5'd1;
            else if (r == 7) phy = 5'd0;
            else phy = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 1) == 0)
                ra = 5'($urandom_range(0, 7));
            else
                ra = 5'($urandom_range(0, 31));
            wd = 16'($urandom);
            if (ra == 5'd0 && $urandom_range(0, 3) != 0)
                wd[15] = 1'b0;
            st1 = ($urandom_range(0, 19) != 0);
            if (prev_clean && $urandom_range(0, 9) == 0) pre = 31;
            else pre = 32 + int'($urandom_range(0, 3));
            link = 1'($urandom_range(0, 1));
            do_frame(pre, st1, op, phy, ra, wd, -1, rd);
        end

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
